mem_resp_ctrl: RTL and testbench

Memory-side responder for the load/store arbitration interface. It accepts one granted operation at a time on `enable`, selects the load or store address with `addr_sel`, and performs a read or write on an internal single-port array after a fixed per-operation latency. It then returns a one-cycle `done` and, for reads, registered `rd_data`. It drives the `idle` input of the arbiter and sits between the arbiter and the backing storage.

---
 rtl/mem_resp_ctrl_pkg.sv | 22 ++
 rtl/mem_resp_ctrl_ram.sv | 34 +++
 rtl/mem_resp_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_resp_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_ctrl_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// operation and address-select codes, and a counter sizing helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    localparam logic SEL_LD  = 1'b0;
    localparam logic SEL_STR = 1'b1;

    // Bits needed to hold (max_lat - 1), never less than one bit.
    function automatic int cnt_width(input int max_lat);
        return (max_lat > 1) ? $clog2(max_lat) : 1;
    endfunction

endpackage

// File: rtl/mem_resp_ctrl_ram.sv
// Single-port synchronous storage behind the responder. Writes and reads
// happen only when enabled, so the registered read word holds between reads.
module mem_resp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array contents are never reset; a write lands only when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read word clears on reset and otherwise only changes on a read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory-side responder: accepts one granted load/store, waits a fixed
// per-operation latency, commits it to the array and pulses done.
module mem_resp_ctrl
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rd_wrt_ca,
    input  logic              addr_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] str_addr,
    input  logic [DATA_W-1:0] str_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              idle
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = cnt_width(MAX_LAT);
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);
    localparam logic RD_FAST = (RD_LAT == 1);
    localparam logic WR_FAST = (WR_LAT == 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              accept;
    logic              fast;
    logic              commit_busy;
    logic              commit_fast;
    logic [ADDR_W-1:0] sel_addr;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    // Decode the request: selected address, single-cycle ops, and acceptance.
    always_comb begin
        sel_addr = (addr_sel == SEL_STR) ? str_addr : ld_addr;
        fast     = (rd_wrt_ca == OP_READ) ? RD_FAST : WR_FAST;
        accept   = ((state == IDLE) || (state == DONE)) && enable;
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept from IDLE/DONE, count down in BUSY, abort on enable low.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (enable) begin
                    state_next = fast ? DONE : BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        done = (state == DONE);
        idle = (state != BUSY);
    end

    // Capture the operation on accept and count the remaining latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            op_q   <= OP_WRITE;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= rd_wrt_ca;
            addr_q <= sel_addr;
            data_q <= str_data;
            cnt    <= (rd_wrt_ca == OP_READ) ? RD_CNT : WR_CNT;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Drive the array only at the commit edge; single-cycle ops use live inputs.
    always_comb begin
        commit_busy = (state == BUSY) && enable && (cnt == '0);
        commit_fast = accept && fast;
        ram_addr    = commit_busy ? addr_q : sel_addr;
        ram_wdata   = commit_busy ? data_q : str_data;
        ram_we      = (commit_busy && (op_q == OP_WRITE)) ||
                      (commit_fast && (rd_wrt_ca == OP_WRITE));
        ram_re      = (commit_busy && (op_q == OP_READ)) ||
                      (commit_fast && (rd_wrt_ca == OP_READ));
    end

    mem_resp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Self-checking bench for mem_resp_ctrl: directed vector table, multi-cycle
// corner sequences, a single-cycle-latency instance, and randomized ops
// compared against an array-based model of the storage.
module tb_mem_resp_ctrl;
    import mem_resp_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              rd_wrt_ca;
    logic              addr_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [ADDR_W-1:0] str_addr;
    logic [DATA_W-1:0] str_data;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              idle;

    logic              f_enable;
    logic              f_rd_wrt_ca;
    logic              f_addr_sel;
    logic [ADDR_W-1:0] f_ld_addr;
    logic [ADDR_W-1:0] f_str_addr;
    logic [DATA_W-1:0] f_str_data;
    logic [DATA_W-1:0] f_rd_data;
    logic              f_done;
    logic              f_idle;

    int n_checks = 0;
    int n_fail = 0;
    int f_idle_low = 0;

    typedef struct {
        logic        op;
        logic        sel;
        logic [7:0]  ld;
        logic [7:0]  st;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          exp_delay;
    } vec_t;

    vec_t vecs [8];

    logic [31:0] model_mem [8];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    mem_resp_ctrl #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_LAT (RD_LAT), .WR_LAT (WR_LAT)
    ) u_dut (
        .clk (clk), .rst (rst), .enable (enable), .rd_wrt_ca (rd_wrt_ca),
        .addr_sel (addr_sel), .ld_addr (ld_addr), .str_addr (str_addr),
        .str_data (str_data), .rd_data (rd_data), .done (done), .idle (idle)
    );

    mem_resp_ctrl #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .RD_LAT (1), .WR_LAT (1)
    ) u_fast (
        .clk (clk), .rst (rst), .enable (f_enable), .rd_wrt_ca (f_rd_wrt_ca),
        .addr_sel (f_addr_sel), .ld_addr (f_ld_addr), .str_addr (f_str_addr),
        .str_data (f_str_data), .rd_data (f_rd_data), .done (f_done), .idle (f_idle)
    );

    // The single-cycle instance must never report busy.
    always @(negedge clk) begin
        if (f_idle !== 1'b1) f_idle_low++;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, %0d checks so far", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one operation and wait for done; returns edges after accept.
    task automatic applyStimulus(input logic op, input logic sel, input logic [7:0] ld,
                                 input logic [7:0] st, input logic [31:0] data,
                                 output int delay, output logic idle_busy);
        enable    = 1'b1;
        rd_wrt_ca = op;
        addr_sel  = sel;
        ld_addr   = ld;
        str_addr  = st;
        str_data  = data;
        @(posedge clk); #1;
        delay     = 0;
        idle_busy = 1'b0;
        while (!done && delay < 20) begin
            if (idle) idle_busy = 1'b1;
            rd_wrt_ca = 1'($urandom_range(0, 1));
            addr_sel  = 1'($urandom_range(0, 1));
            ld_addr   = 8'($urandom);
            str_addr  = 8'($urandom);
            str_data  = $urandom;
            @(posedge clk); #1;
            delay++;
        end
        if (!done) delay = -1;
    endtask

    // Start an operation and drop enable after m extra edges in BUSY.
    task automatic applyAbort(input logic op, input logic sel, input logic [7:0] ld,
                              input logic [7:0] st, input logic [31:0] data,
                              input int m, output logic saw_done);
        enable    = 1'b1;
        rd_wrt_ca = op;
        addr_sel  = sel;
        ld_addr   = ld;
        str_addr  = st;
        str_data  = data;
        @(posedge clk); #1;
        saw_done = done;
        repeat (m) begin
            @(posedge clk); #1;
            saw_done |= done;
        end
        enable = 1'b0;
        @(posedge clk); #1;
        saw_done |= done;
    endtask

    task automatic releaseBus();
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          delay;
        int          gap;
        logic        idle_busy;
        logic        saw_done;
        logic        r_op;
        logic        r_sel;
        logic [7:0]  r_ld;
        logic [7:0]  r_st;
        logic [31:0] r_data;
        logic [2:0]  idx;
        int          lat;

        vecs[0] = '{OP_WRITE, SEL_STR, 8'h00, 8'h10, 32'hDEADBEEF, 32'h00000000, WR_LAT};
        vecs[1] = '{OP_READ,  SEL_LD,  8'h10, 8'h00, 32'h00000000, 32'hDEADBEEF, RD_LAT};
        vecs[2] = '{OP_WRITE, SEL_LD,  8'h01, 8'h02, 32'h11111111, 32'hDEADBEEF, WR_LAT};
        vecs[3] = '{OP_WRITE, SEL_STR, 8'h01, 8'h02, 32'h22222222, 32'hDEADBEEF, WR_LAT};
        vecs[4] = '{OP_READ,  SEL_LD,  8'h01, 8'h02, 32'h00000000, 32'h11111111, RD_LAT};
        vecs[5] = '{OP_READ,  SEL_STR, 8'h01, 8'h02, 32'h00000000, 32'h22222222, RD_LAT};
        vecs[6] = '{OP_WRITE, SEL_STR, 8'h00, 8'h10, 32'hCAFEF00D, 32'h22222222, WR_LAT};
        vecs[7] = '{OP_READ,  SEL_STR, 8'h00, 8'h10, 32'h00000000, 32'hCAFEF00D, RD_LAT};

        rst = 1'b0;
        enable = 1'b0; rd_wrt_ca = 1'b0; addr_sel = 1'b0;
        ld_addr = '0; str_addr = '0; str_data = '0;
        f_enable = 1'b0; f_rd_wrt_ca = 1'b0; f_addr_sel = 1'b0;
        f_ld_addr = '0; f_str_addr = '0; f_str_data = '0;
        #1;
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_idle", 32'(idle), 32'd1);
        checkOutput("reset_rd_data", rd_data, 32'h0);
        checkOutput("reset_fast_done", 32'(f_done), 32'd0);
        checkOutput("reset_fast_idle", 32'(f_idle), 32'd1);
        checkOutput("reset_fast_rd_data", f_rd_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].sel, vecs[i].ld, vecs[i].st, vecs[i].data,
                          delay, idle_busy);
            checkOutput($sformatf("vec%0d_delay", i), 32'(delay), 32'(vecs[i].exp_delay));
            checkOutput($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d_idle_done", i), 32'(idle), 32'd1);
            checkOutput($sformatf("vec%0d_idle_busy", i), 32'(idle_busy), 32'd0);
            releaseBus();
            checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        $display("[TB] back-to-back stores");
        applyStimulus(OP_WRITE, SEL_STR, 8'h00, 8'h30, 32'hA5A50030, delay, idle_busy);
        checkOutput("b2b_first_delay", 32'(delay), 32'(WR_LAT));
        checkOutput("b2b_idle_in_done", 32'(idle), 32'd1);
        rd_wrt_ca = OP_WRITE; addr_sel = SEL_STR; str_addr = 8'h31; str_data = 32'h5A5A0031;
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (!done && gap < 20);
        checkOutput("b2b_done_spacing", 32'(gap), 32'(WR_LAT + 1));
        releaseBus();
        applyStimulus(OP_READ, SEL_LD, 8'h30, 8'h00, 32'h0, delay, idle_busy);
        checkOutput("b2b_read_30", rd_data, 32'hA5A50030);
        releaseBus();
        applyStimulus(OP_READ, SEL_LD, 8'h31, 8'h00, 32'h0, delay, idle_busy);
        checkOutput("b2b_read_31", rd_data, 32'h5A5A0031);
        releaseBus();

        $display("[TB] abort sequences");
        applyAbort(OP_READ, SEL_LD, 8'h30, 8'h00, 32'h0, 0, saw_done);
        checkOutput("abort_rd_no_done", 32'(saw_done), 32'd0);
        checkOutput("abort_rd_idle", 32'(idle), 32'd1);
        checkOutput("abort_rd_data_held", rd_data, 32'h5A5A0031);
        applyAbort(OP_WRITE, SEL_STR, 8'h00, 8'h31, 32'h00000BAD, 0, saw_done);
        checkOutput("abort_wr_no_done", 32'(saw_done), 32'd0);
        applyStimulus(OP_READ, SEL_LD, 8'h31, 8'h00, 32'h0, delay, idle_busy);
        checkOutput("abort_wr_not_written", rd_data, 32'h5A5A0031);
        releaseBus();

        $display("[TB] reset during a write");
        applyStimulus(OP_WRITE, SEL_STR, 8'h00, 8'h20, 32'h5555AAAA, delay, idle_busy);
        releaseBus();
        enable = 1'b1; rd_wrt_ca = OP_WRITE; addr_sel = SEL_STR;
        str_addr = 8'h20; str_data = 32'h00001234;
        @(posedge clk); #1;
        checkOutput("rst_busy_idle", 32'(idle), 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_async_done", 32'(done), 32'd0);
        checkOutput("rst_async_idle", 32'(idle), 32'd1);
        checkOutput("rst_async_rd_data", rd_data, 32'h0);
        enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(OP_READ, SEL_LD, 8'h20, 8'h00, 32'h0, delay, idle_busy);
        checkOutput("rst_write_dropped", rd_data, 32'h5555AAAA);
        releaseBus();

        $display("[TB] single-cycle latency instance");
        f_enable = 1'b1; f_rd_wrt_ca = OP_WRITE; f_addr_sel = SEL_STR;
        f_str_addr = 8'h05; f_str_data = 32'h0F0F0505; f_ld_addr = 8'h06;
        @(posedge clk); #1;
        checkOutput("fast_wr_done", 32'(f_done), 32'd1);
        f_enable = 1'b0;
        @(posedge clk); #1;
        checkOutput("fast_wr_done_clear", 32'(f_done), 32'd0);
        f_enable = 1'b1; f_rd_wrt_ca = OP_READ; f_addr_sel = SEL_LD;
        f_ld_addr = 8'h05; f_str_addr = 8'h06;
        @(posedge clk); #1;
        checkOutput("fast_rd_done", 32'(f_done), 32'd1);
        checkOutput("fast_rd_data", f_rd_data, 32'h0F0F0505);
        f_enable = 1'b0;
        @(posedge clk); #1;
        checkOutput("fast_rd_done_clear", 32'(f_done), 32'd0);
        checkOutput("fast_rd_data_held", f_rd_data, 32'h0F0F0505);
        checkOutput("fast_idle_never_low", 32'(f_idle_low), 32'd0);

        $display("[TB] randomized operations against model");
        for (int i = 0; i < 8; i++) begin
            r_data = $urandom;
            model_mem[i] = r_data;
            applyStimulus(OP_WRITE, SEL_LD, 8'h80 + 8'(i), 8'h00, r_data, delay, idle_busy);
            checkOutput($sformatf("pre%0d_delay", i), 32'(delay), 32'(WR_LAT));
            releaseBus();
        end
        applyStimulus(OP_READ, SEL_STR, 8'h00, 8'h80, 32'h0, delay, idle_busy);
        last_rd = model_mem[0];
        checkOutput("pre_read", rd_data, last_rd);
        releaseBus();

        for (int i = 0; i < 60; i++) begin
            r_op   = 1'($urandom_range(0, 1));
            r_sel  = 1'($urandom_range(0, 1));
            r_ld   = 8'h80 + 8'($urandom_range(0, 7));
            r_st   = 8'h80 + 8'($urandom_range(0, 7));
            r_data = $urandom;
            idx    = (r_sel == SEL_STR) ? r_st[2:0] : r_ld[2:0];
            lat    = (r_op == OP_READ) ? RD_LAT : WR_LAT;
            if (lat > 1 && $urandom_range(0, 3) == 0) begin
                applyAbort(r_op, r_sel, r_ld, r_st, r_data,
                           int'($urandom_range(0, lat - 2)), saw_done);
                checkOutput($sformatf("rnd%0d_abort_no_done", i), 32'(saw_done), 32'd0);
                checkOutput($sformatf("rnd%0d_abort_idle", i), 32'(idle), 32'd1);
                checkOutput($sformatf("rnd%0d_abort_rd_data", i), rd_data, last_rd);
            end else begin
                applyStimulus(r_op, r_sel, r_ld, r_st, r_data, delay, idle_busy);
                if (r_op == OP_WRITE) model_mem[idx] = r_data;
                else last_rd = model_mem[idx];
                checkOutput($sformatf("rnd%0d_delay", i), 32'(delay), 32'(lat));
                checkOutput($sformatf("rnd%0d_rd_data", i), rd_data, last_rd);
                checkOutput($sformatf("rnd%0d_idle_done", i), 32'(idle), 32'd1);
                if ($urandom_range(0, 1) == 0) releaseBus();
            end
        end
        releaseBus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
